// File: rtl/time_set_controller.sv
// time_set_controller
// Front-panel HH:MM setting FSM driven by two debounced buttons (MODE, INC).
// RUN -> SET_HR -> SET_MIN -> COMMIT -> RUN. The module snapshots the running
// time, lets the user edit the hours and then the minutes, and commits the
// edited time to the clock counter with a one-cycle load strobe.
// If no button edge arrives for TIMEOUT_CYCLES in an edit state, the edit is
// abandoned without loading.
// Optional feature macro: BLINK_EN. When it is defined, blank_hr and blank_min
// blink the field being edited with a half-period of BLINK_CYCLES. When it is
// undefined, both outputs are tied low.
module time_set_controller #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int BLINK_CYCLES   = 50
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic [1:0] cur_ms_hr,
    input  logic [3:0] cur_ls_hr,
    input  logic [2:0] cur_ms_min,
    input  logic [3:0] cur_ls_min,
    output logic       load,
    output logic [1:0] load_ms_hr,
    output logic [3:0] load_ls_hr,
    output logic [2:0] load_ms_min,
    output logic [3:0] load_ls_min,
    output logic       edit_active,
    output logic       blank_hr,
    output logic       blank_min
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    state_t          next_state;
    logic            mode_prev;
    logic            inc_prev;
    logic            mode_edge;
    logic            inc_edge;
    logic [TO_W-1:0] timeout_cnt;
    logic            timed_out;

    logic [1:0] edit_ms_hr;
    logic [3:0] edit_ls_hr;
    logic [2:0] edit_ms_min;
    logic [3:0] edit_ls_min;

    logic [5:0] hr_val;
    logic [6:0] min_val;
    logic [1:0] hr_inc_ms;
    logic [3:0] hr_inc_ls;
    logic [2:0] min_inc_ms;
    logic [3:0] min_inc_ls;

    // Each button acts once per press: only a rising edge counts.
    assign mode_edge = mode_btn & ~mode_prev;
    assign inc_edge  = inc_btn & ~inc_prev;
    assign timed_out = (timeout_cnt == TO_LAST);

    // Remember the previous button levels so that edges can be detected.
    // NOTE: registers use non-blocking assignments, so every flop samples its
    // inputs from the same clock edge, independent of the order of statements.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_prev <= 1'b0;
            inc_prev  <= 1'b0;
        end else begin
            mode_prev <= mode_btn;
            inc_prev  <= inc_btn;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= RUN;
        else       state <= next_state;
    end

    // Next-state and Moore outputs. MODE has priority over INC.
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_state  = state;
        load        = 1'b0;
        edit_active = 1'b0;
        case (state)
            RUN: begin
                if (mode_edge) next_state = SET_HR;
            end
            SET_HR: begin
                edit_active = 1'b1;
                if (mode_edge)                  next_state = SET_MIN;
                else if (!inc_edge && timed_out) next_state = RUN;
            end
            SET_MIN: begin
                edit_active = 1'b1;
                if (mode_edge)                  next_state = COMMIT;
                else if (!inc_edge && timed_out) next_state = RUN;
            end
            COMMIT: begin
                load       = 1'b1;
                next_state = RUN;
            end
            default: next_state = RUN;
        endcase
    end

    // Inactivity timer. It restarts on every state change and on every button edge.
    always_ff @(posedge clock) begin
        if (reset)
            timeout_cnt <= '0;
        else if ((next_state != state) || mode_edge || inc_edge)
            timeout_cnt <= '0;
        else if (edit_active)
            timeout_cnt <= timeout_cnt + TO_W'(1);
    end

    // Binary values of the edited fields. Any snapshot at or above the top of
    // its range wraps to 00 on the next INC, which also catches illegal values.
    assign hr_val  = 6'(edit_ms_hr) * 6'd10 + 6'(edit_ls_hr);
    assign min_val = 7'(edit_ms_min) * 7'd10 + 7'(edit_ls_min);

    // BCD increment of the hours field, 00..23.
    always_comb begin
        hr_inc_ms = edit_ms_hr;
        hr_inc_ls = edit_ls_hr;
        if (hr_val >= 6'd23) begin
            hr_inc_ms = 2'd0;
            hr_inc_ls = 4'd0;
        end else if (edit_ls_hr >= 4'd9) begin
            hr_inc_ms = edit_ms_hr + 2'd1;
            hr_inc_ls = 4'd0;
        end else begin
            hr_inc_ls = edit_ls_hr + 4'd1;
        end
    end

    // BCD increment of the minutes field, 00..59. It never carries into the hours.
    always_comb begin
        min_inc_ms = edit_ms_min;
        min_inc_ls = edit_ls_min;
        if (min_val >= 7'd59) begin
            min_inc_ms = 3'd0;
            min_inc_ls = 4'd0;
        end else if (edit_ls_min >= 4'd9) begin
            min_inc_ms = edit_ms_min + 3'd1;
            min_inc_ls = 4'd0;
        end else begin
            min_inc_ls = edit_ls_min + 4'd1;
        end
    end

    // Edit registers: snapshot on entering SET_HR, then step the active field
    // on INC. An INC edge that coincides with a MODE edge is discarded.
    always_ff @(posedge clock) begin
        if (reset) begin
            edit_ms_hr  <= '0;
            edit_ls_hr  <= '0;
            edit_ms_min <= '0;
            edit_ls_min <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mode_edge) begin
                        edit_ms_hr  <= cur_ms_hr;
                        edit_ls_hr  <= cur_ls_hr;
                        edit_ms_min <= cur_ms_min;
                        edit_ls_min <= cur_ls_min;
                    end
                end
                SET_HR: begin
                    if (inc_edge && !mode_edge) begin
                        edit_ms_hr <= hr_inc_ms;
                        edit_ls_hr <= hr_inc_ls;
                    end
                end
                SET_MIN: begin
                    if (inc_edge && !mode_edge) begin
                        edit_ms_min <= min_inc_ms;
                        edit_ls_min <= min_inc_ls;
                    end
                end
                default: ;
            endcase
        end
    end

    // The load value always shows the edit registers. It is valid whenever load is high.
    assign load_ms_hr  = edit_ms_hr;
    assign load_ls_hr  = edit_ls_hr;
    assign load_ms_min = edit_ms_min;
    assign load_ls_min = edit_ls_min;

`ifdef BLINK_EN
    localparam int BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);

    logic [BL_W-1:0] blink_cnt;
    logic            blink_phase;

    // Blink timer: it flips the phase every BLINK_CYCLES while editing and
    // restarts from phase 0 on every state change.
    always_ff @(posedge clock) begin
        if (reset || (next_state != state)) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (edit_active) begin
            if (blink_cnt == BL_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BL_W'(1);
            end
        end
    end

    assign blank_hr  = blink_phase & (state == SET_HR);
    assign blank_min = blink_phase & (state == SET_MIN);
`else
    // Without blinking the blink period has no use. It is folded into a sink
    // signal so that the parameter stays referenced.
    logic unused_blink_cfg;
    assign unused_blink_cfg = ^BLINK_CYCLES;
    assign blank_hr  = 1'b0;
    assign blank_min = 1'b0;
`endif

endmodule

// File: tb/tb_time_set_controller.sv
// tb_time_set_controller
// Directed and random stimulus for time_set_controller. The expected outputs
// come from a behavioural model that tracks the edit phase and holds the
// hours and minutes as plain integers. Set BLINK_EN to the same value for the
// bench and the design.
module tb_time_set_controller;

    localparam int T = 64;
    localparam int B = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       mode_btn;
    logic       inc_btn;
    logic [1:0] cur_ms_hr;
    logic [3:0] cur_ls_hr;
    logic [2:0] cur_ms_min;
    logic [3:0] cur_ls_min;
    logic       load;
    logic [1:0] load_ms_hr;
    logic [3:0] load_ls_hr;
    logic [2:0] load_ms_min;
    logic [3:0] load_ls_min;
    logic       edit_active;
    logic       blank_hr;
    logic       blank_min;

    time_set_controller #(.TIMEOUT_CYCLES(T), .BLINK_CYCLES(B)) dut (
        .clock       (clock),
        .reset       (reset),
        .mode_btn    (mode_btn),
        .inc_btn     (inc_btn),
        .cur_ms_hr   (cur_ms_hr),
        .cur_ls_hr   (cur_ls_hr),
        .cur_ms_min  (cur_ms_min),
        .cur_ls_min  (cur_ls_min),
        .load        (load),
        .load_ms_hr  (load_ms_hr),
        .load_ls_hr  (load_ls_hr),
        .load_ms_min (load_ms_min),
        .load_ls_min (load_ls_min),
        .edit_active (edit_active),
        .blank_hr    (blank_hr),
        .blank_min   (blank_min)
    );

    always #5 clock = ~clock;

    int n_asserts = 0;
    int n_fail    = 0;

    // Model: phase 0 = running, 1 = editing hours, 2 = editing minutes, 3 = commit
    int m_phase = 0;
    int m_hr    = 0;
    int m_min   = 0;
    int m_idle  = 0;   // cycles without a button edge in the current edit phase
    int m_dwell = 0;   // cycles since the current phase was entered
    bit m_prev_mode = 1'b0;
    bit m_prev_inc  = 1'b0;

    int load_pulses = 0;
    int last_load   = -1;  // HHMM value seen while load was high

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit me;
        bit ie;
        int old;
        me = mode_btn && !m_prev_mode;
        ie = inc_btn && !m_prev_inc;
        if (reset) begin
            m_phase = 0; m_hr = 0; m_min = 0; m_idle = 0; m_dwell = 0;
            m_prev_mode = 1'b0; m_prev_inc = 1'b0;
            return;
        end
        m_prev_mode = mode_btn;
        m_prev_inc  = inc_btn;
        old = m_phase;
        case (m_phase)
            0: if (me) begin
                   m_hr    = int'(cur_ms_hr) * 10 + int'(cur_ls_hr);
                   m_min   = int'(cur_ms_min) * 10 + int'(cur_ls_min);
                   m_phase = 1;
               end
            1: if (me) m_phase = 2;
               else if (ie) m_hr = (m_hr >= 23) ? 0 : m_hr + 1;
               else if (m_idle == T - 1) m_phase = 0;
            2: if (me) m_phase = 3;
               else if (ie) m_min = (m_min >= 59) ? 0 : m_min + 1;
               else if (m_idle == T - 1) m_phase = 0;
            default: m_phase = 0;
        endcase
        if (m_phase != old || me || ie) m_idle = 0;
        else if (m_phase == 1 || m_phase == 2) m_idle++;
        if (m_phase != old) m_dwell = 0;
        else m_dwell++;
    endtask

    task automatic check_outputs();
        bit blink_on;
        chk("load", 32'(load), 32'(m_phase == 3));
        chk("load_time", 32'({load_ms_hr, load_ls_hr, load_ms_min, load_ls_min}),
            32'({2'(m_hr / 10), 4'(m_hr % 10), 3'(m_min / 10), 4'(m_min % 10)}));
        chk("edit_active", 32'(edit_active), 32'(m_phase == 1 || m_phase == 2));
`ifdef BLINK_EN
        blink_on = ((m_dwell / B) % 2) == 1;
`else
        blink_on = 1'b0;
`endif
        chk("blank", 32'({blank_hr, blank_min}),
            32'({blink_on && m_phase == 1, blink_on && m_phase == 2}));
        if (load === 1'b1) begin
            load_pulses++;
            last_load = int'(load_ms_hr) * 1000 + int'(load_ls_hr) * 100 +
                        int'(load_ms_min) * 10 + int'(load_ls_min);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic press_mode();
        mode_btn = 1'b1; cycle();
        mode_btn = 1'b0; cycle();
    endtask

    task automatic press_inc();
        inc_btn = 1'b1; cycle();
        inc_btn = 1'b0; cycle();
    endtask

    task automatic set_cur(input int hh, input int mm);
        cur_ms_hr  = 2'(hh / 10);
        cur_ls_hr  = 4'(hh % 10);
        cur_ms_min = 3'(mm / 10);
        cur_ls_min = 4'(mm % 10);
    endtask

    initial begin
        int hi;
        reset = 1'b1; mode_btn = 1'b0; inc_btn = 1'b0;
        set_cur(0, 0);

        // Reset, then stay idle
        idle(3);
        reset = 1'b0;
        idle(20);
        chk("idle_no_load", 32'(load_pulses), 32'd0);

        // 12:34 edited to 15:36
        set_cur(12, 34);
        load_pulses = 0;
        press_mode();
        repeat (3) press_inc();
        press_mode();
        repeat (2) press_inc();
        press_mode();
        idle(2);
        chk("pulses_1234", 32'(load_pulses), 32'd1);
        chk("value_1536", 32'(last_load), 32'd1536);

        // 23:59 wraps to 00:00, and the minute wrap leaves the hours alone
        set_cur(23, 59);
        load_pulses = 0;
        press_mode(); press_inc();
        press_mode(); press_inc();
        press_mode();
        idle(2);
        chk("pulses_2359", 32'(load_pulses), 32'd1);
        chk("value_0000", 32'(last_load), 32'd0);

        // MODE and INC edges together: MODE wins, hours unchanged
        set_cur(8, 15);
        load_pulses = 0;
        press_mode();
        mode_btn = 1'b1; inc_btn = 1'b1; cycle();
        mode_btn = 1'b0; inc_btn = 1'b0; cycle();
        chk("both_in_set_min", 32'(edit_active), 32'd1);
        chk("both_hours_kept", 32'(int'(load_ms_hr) * 10 + int'(load_ls_hr)), 32'd8);
        idle(T + 2);   // the timeout also fires in SET_MIN
        chk("min_timeout_run", 32'(edit_active), 32'd0);
        chk("min_timeout_no_load", 32'(load_pulses), 32'd0);

        // SET_HR timeout: edit stays active for exactly T cycles
        mode_btn = 1'b1; cycle();
        mode_btn = 1'b0;
        hi = 0;
        for (int k = 0; k < 2 * T && edit_active === 1'b1; k++) begin
            hi++;
            cycle();
        end
        chk("hr_timeout_len", 32'(hi), 32'(T));
        chk("hr_timeout_no_load", 32'(load_pulses), 32'd0);

        // Reset in SET_MIN aborts the edit with no load
        press_mode(); press_mode();
        reset = 1'b1; cycle();
        reset = 1'b0;
        idle(5);
        chk("reset_abort_no_load", 32'(load_pulses), 32'd0);

        // Out-of-range hours snapshot (27) saturates to 00
        cur_ms_hr = 2'd2; cur_ls_hr = 4'd7; cur_ms_min = 3'd4; cur_ls_min = 4'd5;
        press_mode(); press_inc();
        chk("sat_hours", 32'(int'(load_ms_hr) * 10 + int'(load_ls_hr)), 32'd0);
        press_mode(); press_inc(); press_mode();
        idle(2);
        chk("sat_value", 32'(last_load), 32'd46);

        // Random button activity with periodic quiet spells and rare resets
        for (int k = 0; k < 2000; k++) begin
            if ((k % 400) >= 320) begin
                mode_btn = 1'b0;
                inc_btn  = 1'b0;
            end else begin
                mode_btn = ($urandom_range(0, 5) == 0);
                inc_btn  = ($urandom_range(0, 2) == 0);
            end
            if ($urandom_range(0, 49) == 0)
                set_cur(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)));
            reset = ($urandom_range(0, 299) == 0);
            cycle();
        end
        reset = 1'b0;
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
